// File: rtl/row_sync_arbiter_if.sv
// Core-side bundle of the row arbiter: request/lock levels in, grant and barrier status out.
// The arbiter connects through the slave modport; the cores' side uses master.
interface row_sync_arbiter_if #(
    parameter int NUM_CORES = 4
);
    localparam int ID_W = $clog2(NUM_CORES);

    logic [NUM_CORES-1:0] i_core_req;
    logic [NUM_CORES-1:0] i_core_locked;
    logic                 i_drain_done;
    logic [NUM_CORES-1:0] o_core_grant;
    logic [ID_W-1:0]      o_grant_id;
    logic                 o_uram_emptied;
    logic                 o_drain_start;
    logic                 o_timeout_err;

    modport slave (
        input  i_core_req, i_core_locked, i_drain_done,
        output o_core_grant, o_grant_id, o_uram_emptied, o_drain_start, o_timeout_err
    );

    modport master (
        output i_core_req, i_core_locked, i_drain_done,
        input  o_core_grant, o_grant_id, o_uram_emptied, o_drain_start, o_timeout_err
    );
endinterface

// File: rtl/row_sync_arbiter.sv
// Round-robin owner arbitration for the shared URAM plus an all-cores-locked barrier
// that runs one drain handshake before releasing the cores via o_uram_emptied.
module row_sync_arbiter #(
    parameter int NUM_CORES       = 4,
    parameter int MAX_HOLD_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               reset_n,
    row_sync_arbiter_if.slave  bus
);
    localparam int ID_W  = $clog2(NUM_CORES);
    localparam int CNT_W = $clog2(MAX_HOLD_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_ARB,
        ST_HOLD,
        ST_DRAIN,
        ST_EMPTIED
    } state_e;

    state_e               state_q,    state_d;
    logic [ID_W-1:0]      rr_ptr_q,   rr_ptr_d;
    logic [CNT_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic [NUM_CORES-1:0] grant_q,    grant_d;
    logic [ID_W-1:0]      grant_id_q, grant_id_d;
    logic                 timeout_q,  timeout_d;

    logic [NUM_CORES-1:0] eligible;
    logic                 pick_found;
    logic [ID_W-1:0]      pick_id;

    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_CORES) sum = sum - NUM_CORES;
        return ID_W'(sum);
    endfunction

    assign eligible = bus.i_core_req & ~bus.i_core_locked;

    // Scan downward so the last hit, i.e. the nearest at or after rr_ptr, wins.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        for (int off = NUM_CORES - 1; off >= 0; off--) begin
            if (eligible[wrap_add(rr_ptr_q, off)]) begin
                pick_found = 1'b1;
                pick_id    = wrap_add(rr_ptr_q, off);
            end
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        timeout_d  = 1'b0;

        case (state_q)
            ST_ARB: begin
                if (&bus.i_core_locked) begin
                    state_d = ST_DRAIN;
                end else if (pick_found) begin
                    grant_d    = NUM_CORES'(1) << pick_id;
                    grant_id_d = pick_id;
                    hold_cnt_d = '0;
                    state_d    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                hold_cnt_d = hold_cnt_q + 1'b1;
                if (!bus.i_core_req[grant_id_q] || hold_cnt_q == HOLD_LAST) begin
                    grant_d   = '0;
                    rr_ptr_d  = wrap_add(grant_id_q, 1);
                    state_d   = ST_ARB;
                    timeout_d = bus.i_core_req[grant_id_q];
                end
            end
            ST_DRAIN: begin
                if (bus.i_drain_done) state_d = ST_EMPTIED;
            end
            ST_EMPTIED: begin
                if (bus.i_core_locked == '0) state_d = ST_ARB;
            end
            default: state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_ARB;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
            grant_q    <= '0;
            grant_id_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.o_core_grant   = grant_q;
    assign bus.o_grant_id     = grant_id_q;
    assign bus.o_timeout_err  = timeout_q;
    assign bus.o_drain_start  = (state_q == ST_DRAIN);
    assign bus.o_uram_emptied = (state_q == ST_EMPTIED);
endmodule

// File: tb/tb_row_sync_arbiter.sv
// Directed bench for row_sync_arbiter: a cycle model built on owner/turn/phase bookkeeping
// is compared on every falling edge, with literal expectations for each scenario.
module tb_row_sync_arbiter;
    localparam int N        = 4;
    localparam int MAX_HOLD = 8;

    typedef enum int {P_OPEN, P_DRAIN, P_RELEASE} phase_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    row_sync_arbiter_if #(.NUM_CORES(N)) bus ();

    row_sync_arbiter #(.NUM_CORES(N), .MAX_HOLD_CYCLES(MAX_HOLD)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_bound(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: wait budget expired at %0t", name, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Model: who owns the URAM (-1 none), whose turn starts the search, how long the owner held it.
    int     m_owner;
    int     m_turn;
    int     m_held;
    int     m_last_id;
    phase_t m_phase;
    bit     m_to;

    task automatic model_next(input logic [N-1:0] req, input logic [N-1:0] lock, input logic done,
                              output int owner, output int turn, output int held,
                              output int last_id, output phase_t phase, output bit to);
        owner = m_owner; turn = m_turn; held = m_held;
        last_id = m_last_id; phase = m_phase; to = 1'b0;
        if (phase == P_DRAIN) begin
            if (done) phase = P_RELEASE;
        end else if (phase == P_RELEASE) begin
            if (lock == '0) phase = P_OPEN;
        end else if (owner >= 0) begin
            held++;
            if (!req[owner]) begin
                turn = (owner + 1) % N;
                owner = -1;
            end else if (held == MAX_HOLD) begin
                turn = (owner + 1) % N;
                owner = -1;
                to = 1'b1;
            end
        end else if (lock == {N{1'b1}}) begin
            phase = P_DRAIN;
        end else begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (turn + k) % N;
                if (owner < 0 && req[c] && !lock[c]) begin
                    owner = c;
                    last_id = c;
                    held = 0;
                end
            end
        end
    endtask

    always @(posedge clk or negedge reset_n) begin : model_proc
        int o, t, h, li;
        phase_t p;
        bit to;
        if (!reset_n) begin
            m_owner <= -1; m_turn <= 0; m_held <= 0;
            m_last_id <= 0; m_phase <= P_OPEN; m_to <= 1'b0;
        end else begin
            model_next(bus.i_core_req, bus.i_core_locked, bus.i_drain_done, o, t, h, li, p, to);
            m_owner <= o; m_turn <= t; m_held <= h;
            m_last_id <= li; m_phase <= p; m_to <= to;
        end
    end

    function automatic logic [N-1:0] model_grant();
        return (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    endfunction

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            check("cmp_grant", 32'(bus.o_core_grant), 32'(model_grant()));
            check("cmp_onehot0", 32'($onehot0(bus.o_core_grant)), 32'd1);
            if (m_owner >= 0) check("cmp_grant_id", 32'(bus.o_grant_id), 32'(m_last_id));
            check("cmp_drain_start", 32'(bus.o_drain_start), 32'(m_phase == P_DRAIN));
            check("cmp_emptied", 32'(bus.o_uram_emptied), 32'(m_phase == P_RELEASE));
            check("cmp_timeout", 32'(bus.o_timeout_err), 32'(m_to));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        int n, idle, cnt, id;
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};

        reset_n = 1'b0;
        bus.i_core_req    = '0;
        bus.i_core_locked = '0;
        bus.i_drain_done  = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_grant", 32'(bus.o_core_grant), 32'd0);
        check("rst_grant_id", 32'(bus.o_grant_id), 32'd0);
        check("rst_emptied", 32'(bus.o_uram_emptied), 32'd0);
        check("rst_drain", 32'(bus.o_drain_start), 32'd0);
        check("rst_timeout", 32'(bus.o_timeout_err), 32'd0);
        reset_n = 1'b1;

        // Reset arriving in the middle of a hold.
        bus.i_core_req = 4'b0100;
        step();
        check("t1_first_grant", 32'(bus.o_core_grant), 32'h4);
        step();
        step();
        check("t1_mid_hold", 32'(bus.o_core_grant), 32'h4);
        reset_n = 1'b0;
        #1;
        check("t1_async_grant", 32'(bus.o_core_grant), 32'd0);
        check("t1_async_emptied", 32'(bus.o_uram_emptied), 32'd0);
        check("t1_async_drain", 32'(bus.o_drain_start), 32'd0);
        bus.i_core_req = 4'b1111;
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        step();
        check("t1_after_reset", 32'(bus.o_core_grant), 32'h1);
        bus.i_core_req = 4'b1110;
        step();
        check("t1_release", 32'(bus.o_core_grant), 32'd0);
        bus.i_core_req = '0;
        step();

        // Round robin with every core holding for three cycles.
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        bus.i_core_req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            n = 0;
            idle = 0;
            do begin
                step();
                n++;
                bus.i_core_req = 4'b1111;
                if (bus.o_core_grant == '0) idle++;
            end while (bus.o_core_grant == '0 && n < 20);
            if (bus.o_core_grant == '0) fail_bound("t2_wait_grant");
            id = int'(bus.o_grant_id);
            check("t2_order", 32'(id), 32'(exp_order[g]));
            if (g > 0) check("t2_idle_gap", 32'(idle), 32'd1);
            step();
            step();
            check("t2_held_3", 32'(bus.o_core_grant), 32'(N'(1) << exp_order[g]));
            bus.i_core_req = 4'b1111 & ~(N'(1) << id);
        end
        step();
        bus.i_core_req = '0;
        step();

        // Locked core 1 is skipped even though the turn points at it.
        bus.i_core_locked = 4'b0010;
        bus.i_core_req    = 4'b0011;
        step();
        check("t3_grant_core0", 32'(bus.o_core_grant), 32'h1);
        repeat (3) step();
        check("t3_still_core0", 32'(bus.o_core_grant), 32'h1);
        bus.i_core_req = 4'b0010;
        step();
        check("t3_release", 32'(bus.o_core_grant), 32'd0);
        repeat (3) step();
        check("t3_locked_never", 32'(bus.o_core_grant), 32'd0);
        bus.i_core_locked = '0;
        bus.i_core_req    = '0;
        step();

        // Core 2 never lets go; forced revoke after MAX_HOLD grant cycles.
        bus.i_core_req = 4'b1100;
        step();
        check("t4_grant_core2", 32'(bus.o_core_grant), 32'h4);
        cnt = 1;
        n = 0;
        while (bus.o_core_grant == 4'b0100 && n < 20) begin
            step();
            n++;
            if (bus.o_core_grant == 4'b0100) cnt++;
        end
        if (bus.o_core_grant == 4'b0100) fail_bound("t4_wait_revoke");
        check("t4_hold_len", 32'(cnt), 32'd8);
        check("t4_timeout_pulse", 32'(bus.o_timeout_err), 32'd1);
        step();
        check("t4_timeout_single", 32'(bus.o_timeout_err), 32'd0);
        check("t4_next_core3", 32'(bus.o_core_grant), 32'h8);
        bus.i_core_req = '0;
        step();

        // Stray drain-done pulses in ARB and HOLD.
        bus.i_drain_done = 1'b1;
        step();
        bus.i_drain_done = 1'b0;
        check("t6_arb_emptied", 32'(bus.o_uram_emptied), 32'd0);
        check("t6_arb_drain", 32'(bus.o_drain_start), 32'd0);
        bus.i_core_req = 4'b0001;
        step();
        check("t6_grant_core0", 32'(bus.o_core_grant), 32'h1);
        bus.i_drain_done = 1'b1;
        step();
        bus.i_drain_done = 1'b0;
        check("t6_hold_grant", 32'(bus.o_core_grant), 32'h1);
        check("t6_hold_emptied", 32'(bus.o_uram_emptied), 32'd0);
        bus.i_core_req = '0;
        step();
        check("t6_release", 32'(bus.o_core_grant), 32'd0);

        // Barrier: lock ramp, drain handshake, staggered unlock.
        bus.i_core_locked = 4'b0001;
        step();
        bus.i_core_locked = 4'b0011;
        step();
        bus.i_core_locked = 4'b0111;
        step();
        check("t5_no_drain_yet", 32'(bus.o_drain_start), 32'd0);
        bus.i_core_locked = 4'b1111;
        step();
        check("t5_drain_start", 32'(bus.o_drain_start), 32'd1);
        bus.i_core_req = 4'b1111;
        step();
        check("t5_drain_no_grant", 32'(bus.o_core_grant), 32'd0);
        bus.i_core_locked = 4'b1011;
        step();
        check("t5_drain_kept", 32'(bus.o_drain_start), 32'd1);
        bus.i_drain_done = 1'b1;
        step();
        bus.i_drain_done = 1'b0;
        check("t5_emptied", 32'(bus.o_uram_emptied), 32'd1);
        check("t5_drain_off", 32'(bus.o_drain_start), 32'd0);
        bus.i_core_req    = 4'b0100;
        bus.i_core_locked = 4'b1010;
        step();
        check("t5_emptied_held", 32'(bus.o_uram_emptied), 32'd1);
        check("t5_req_ignored", 32'(bus.o_core_grant), 32'd0);
        bus.i_core_locked = 4'b1000;
        step();
        check("t5_emptied_held2", 32'(bus.o_uram_emptied), 32'd1);
        bus.i_core_locked = 4'b0000;
        step();
        check("t5_emptied_drop", 32'(bus.o_uram_emptied), 32'd0);
        check("t5_no_grant_on_exit", 32'(bus.o_core_grant), 32'd0);
        step();
        check("t5_grant_after_arb", 32'(bus.o_core_grant), 32'h4);
        bus.i_core_req = '0;
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
